rib_timer: RTL

- RIB slave (responder) implementing a machine timer: 64-bit free-running `mtime`, 64-bit `mtimecmp`, control register, level interrupt.
- Attaches to the peripheral RIB port, the `o_ribp_*`/`i_ribp_*` side of the core top, behind the interconnect; the upstream slave-select has already decoded the high address byte.
- Answers master requests with the RIB gnt/rsp/rdy handshake.
- Drives the core's timer interrupt line.

---
 rtl/rib_timer_pkg.sv | 36 +++
 rtl/rib_slave_if.sv | 47 ++++
 rtl/rib_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rib_timer_pkg.sv
// Shared RIB definitions: transfer direction, timer register offsets and
// control-register fields, plus a byte-lane merge helper.
package rib_timer_pkg;

  localparam logic RIB_WR = 1'b1;
  localparam logic RIB_RD = 1'b0;

  localparam logic [2:0] TMR_MTIME_LO = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI = 3'd1;
  localparam logic [2:0] TMR_CMP_LO   = 3'd2;
  localparam logic [2:0] TMR_CMP_HI   = 3'd3;
  localparam logic [2:0] TMR_CTRL     = 3'd4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  typedef struct packed {
    logic [2:0]  sel;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } rib_req_t;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rib_slave_if.sv
// Generic RIB responder handshake: grant while no response is stuck,
// one-cycle response latency, response data held until the master takes it.
module rib_slave_if #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req,
  input  logic              i_rdy,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_gnt,
  output logic              o_accept,
  output logic              o_rsp,
  output logic [DATA_W-1:0] o_rdata
);

  logic              rsp_q, rsp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign o_gnt    = !rsp_q | i_rdy;
  assign o_accept = i_req & o_gnt;

  always_comb begin
    rsp_d   = rsp_q;
    rdata_d = rdata_q;
    if (o_accept) begin
      rsp_d   = 1'b1;
      rdata_d = i_rdata;
    end else if (i_rdy) begin
      rsp_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_rsp   = rsp_q;
  assign o_rdata = rdata_q;

endmodule

// File: rtl/rib_timer.sv
// RIB machine timer: 64-bit mtime with prescaled tick, 64-bit compare,
// control register and a registered level interrupt.
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PRESC_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [ADDR_W-1:0] i_ribs_addr,
  input  logic              i_ribs_wrcs,
  input  logic [3:0]        i_ribs_mask,
  input  logic [31:0]       i_ribs_wdata,
  output logic [31:0]       o_ribs_rdata,
  input  logic              i_ribs_req,
  output logic              o_ribs_gnt,
  output logic              o_ribs_rsp,
  input  logic              i_ribs_rdy,
  output logic              o_timer_irq
);

  rib_req_t           req;
  logic               accept, wr_en;
  logic [31:0]        rd_val;
  logic [63:0]        mtime_q, mtime_d, mtime_inc;
  logic [63:0]        cmp_q, cmp_d;
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               tick;
  logic               irq_q;
  logic               unused_addr;

  assign req.sel   = i_ribs_addr[4:2];
  assign req.wr    = i_ribs_wrcs;
  assign req.mask  = i_ribs_mask;
  assign req.wdata = i_ribs_wdata;
  assign unused_addr = ^{i_ribs_addr[ADDR_W-1:5], i_ribs_addr[1:0]};

  rib_slave_if #(.DATA_W(32)) u_if (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_req    (i_ribs_req),
    .i_rdy    (i_ribs_rdy),
    .i_rdata  (rd_val),
    .o_gnt    (o_ribs_gnt),
    .o_accept (accept),
    .o_rsp    (o_ribs_rsp),
    .o_rdata  (o_ribs_rdata)
  );

  assign wr_en = accept & (req.wr == RIB_WR);

  // Reads see pre-update state; writes always return zero data.
  always_comb begin
    rd_val = '0;
    if (req.wr == RIB_RD) begin
      case (req.sel)
        TMR_MTIME_LO: rd_val = mtime_q[31:0];
        TMR_MTIME_HI: rd_val = mtime_q[63:32];
        TMR_CMP_LO:   rd_val = cmp_q[31:0];
        TMR_CMP_HI:   rd_val = cmp_q[63:32];
        TMR_CTRL: begin
          rd_val[CTRL_EN_BIT]             = en_q;
          rd_val[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
        end
        default:      rd_val = '0;
      endcase
    end
  end

  // A PRESC lowered below the running count lets the counter wrap naturally.
  assign tick = en_q & (cnt_q == presc_q);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_q || tick) cnt_d = '0;
  end

  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    mtime_d = mtime_inc;
    cmp_d   = cmp_q;
    en_d    = en_q;
    presc_d = presc_q;
    if (wr_en) begin
      case (req.sel)
        TMR_MTIME_LO: mtime_d[31:0]  = byte_merge(mtime_inc[31:0],  req.wdata, req.mask);
        TMR_MTIME_HI: mtime_d[63:32] = byte_merge(mtime_inc[63:32], req.wdata, req.mask);
        TMR_CMP_LO:   cmp_d[31:0]    = byte_merge(cmp_q[31:0],      req.wdata, req.mask);
        TMR_CMP_HI:   cmp_d[63:32]   = byte_merge(cmp_q[63:32],     req.wdata, req.mask);
        TMR_CTRL: begin
          if (req.mask[0]) en_d = req.wdata[CTRL_EN_BIT];
          if (req.mask[1]) presc_d = req.wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      irq_q   <= en_q & (mtime_q >= cmp_q);
    end
  end

  assign o_timer_irq = irq_q;

endmodule
